// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register target.
package spi_pkg;

    localparam int HDR_BITS  = 8;
    localparam int DATA_BITS = 8;

    typedef struct packed {
        logic       rd_wr;
        logic [6:0] addr;
    } spi_hdr_t;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        DONE
    } spi_tgt_state_t;

    function automatic logic f_in_range(input logic [6:0] addr, input int num_regs);
        return int'(addr) < num_regs;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with edge pulses derived
// from the synchronized level (one mclk cycle wide).
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 responder with an addressed 8-bit register bank and a local access port.
// Define SPI_TGT_BURST_EN for auto-incrementing multi-byte frames.
module spi_reg_target
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_mclk,
    input  logic       i_reset,
    input  logic       i_sclk,
    input  logic       i_cs,
    input  logic       i_mosi,
    output logic       o_miso,
    input  logic [6:0] i_loc_addr,
    output logic [7:0] o_loc_rdata,
    input  logic       i_loc_we,
    input  logic [7:0] i_loc_wdata,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_busy,
    output logic       o_addr_err
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_mclk), .i_reset(i_reset), .i_d(i_sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(i_mclk), .i_reset(i_reset), .i_d(i_cs),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_mclk), .i_reset(i_reset), .i_d(i_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sclk_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall};

    spi_tgt_state_t r_state;
    logic [2:0]     r_cnt;
    logic [7:0]     r_shreg;
    logic           r_rd_wr;
    logic [6:0]     r_addr;
    logic           r_miso;
    logic           r_addr_err;
    logic           r_cm_vld;
    logic [6:0]     r_cm_addr;
    logic [7:0]     r_cm_data;

    logic [7:0]     r_bank [NUM_REGS];
    logic           r_wr_valid;
    logic [6:0]     r_wr_addr;
    logic [7:0]     r_wr_data;

    logic [7:0]     w_shin;
    spi_hdr_t       w_hdr;
    logic [7:0]     w_hdr_rdata;
    logic           w_last;

    assign w_shin      = {r_shreg[6:0], w_mosi};
    assign w_hdr       = spi_hdr_t'(w_shin);
    assign w_last      = (r_cnt == 3'(HDR_BITS - 1));
    assign w_hdr_rdata = f_in_range(w_hdr.addr, NUM_REGS) ? r_bank[w_hdr.addr[AW-1:0]] : 8'h00;
    assign o_loc_rdata = f_in_range(i_loc_addr, NUM_REGS) ? r_bank[i_loc_addr[AW-1:0]] : 8'h00;

`ifdef SPI_TGT_BURST_EN
    logic [6:0] w_next_addr;
    logic [7:0] w_next_rdata;
    assign w_next_addr  = (int'(r_addr) >= NUM_REGS - 1) ? 7'd0 : r_addr + 7'd1;
    assign w_next_rdata = r_bank[w_next_addr[AW-1:0]];
`endif

    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_shreg    <= 8'h00;
            r_rd_wr    <= 1'b0;
            r_addr     <= 7'd0;
            r_miso     <= 1'b0;
            r_addr_err <= 1'b0;
            r_cm_vld   <= 1'b0;
            r_cm_addr  <= 7'd0;
            r_cm_data  <= 8'h00;
        end else begin
            r_addr_err <= 1'b0;
            r_cm_vld   <= 1'b0;
            if (w_cs_rise) begin
                r_state <= IDLE;
                r_cnt   <= 3'd0;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state <= HEADER;
                            r_cnt   <= 3'd0;
                            r_miso  <= 1'b0;
                        end
                    end
                    HEADER: begin
                        if (w_sclk_rise) begin
                            r_cnt   <= r_cnt + 3'd1;
                            r_shreg <= w_shin;
                            if (w_last) begin
                                r_rd_wr    <= w_hdr.rd_wr;
                                r_addr     <= w_hdr.addr;
                                r_addr_err <= !f_in_range(w_hdr.addr, NUM_REGS);
                                r_shreg    <= w_hdr_rdata;
                                r_state    <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (r_rd_wr && w_sclk_fall) begin
                            r_miso  <= r_shreg[7];
                            r_shreg <= {r_shreg[6:0], 1'b0};
                        end
                        if (w_sclk_rise) begin
                            r_cnt <= r_cnt + 3'd1;
                            if (!r_rd_wr) r_shreg <= w_shin;
                            if (w_last) begin
                                // Out-of-range writes are silently dropped here.
                                if (!r_rd_wr && f_in_range(r_addr, NUM_REGS)) begin
                                    r_cm_vld  <= 1'b1;
                                    r_cm_addr <= r_addr;
                                    r_cm_data <= w_shin;
                                end
`ifdef SPI_TGT_BURST_EN
                                r_addr <= w_next_addr;
                                if (r_rd_wr) r_shreg <= w_next_rdata;
`else
                                r_state <= DONE;
                                r_miso  <= 1'b0;
`endif
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // SPI commit is assigned last so it overrides a same-address local write.
    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_bank[i] <= 8'h00;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= 8'h00;
        end else begin
            r_wr_valid <= r_cm_vld;
            if (i_loc_we && f_in_range(i_loc_addr, NUM_REGS))
                r_bank[i_loc_addr[AW-1:0]] <= i_loc_wdata;
            if (r_cm_vld) begin
                r_bank[r_cm_addr[AW-1:0]] <= r_cm_data;
                r_wr_addr <= r_cm_addr;
                r_wr_data <= r_cm_data;
            end
        end
    end

    assign o_miso     = r_miso;
    assign o_busy     = (r_state != IDLE);
    assign o_addr_err = r_addr_err;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench for spi_reg_target: register-bank model plus expected-write queue.
module tb_spi_reg_target;

    logic       i_mclk, i_reset, i_sclk, i_cs, i_mosi, o_miso;
    logic [6:0] i_loc_addr;
    logic [7:0] o_loc_rdata, i_loc_wdata;
    logic       i_loc_we, o_wr_valid, o_busy, o_addr_err;
    logic [6:0] o_wr_addr;
    logic [7:0] o_wr_data;

    spi_reg_target #(.NUM_REGS(16), .SYNC_STAGES(2)) dut (
        .i_mclk(i_mclk), .i_reset(i_reset), .i_sclk(i_sclk), .i_cs(i_cs),
        .i_mosi(i_mosi), .o_miso(o_miso), .i_loc_addr(i_loc_addr),
        .o_loc_rdata(o_loc_rdata), .i_loc_we(i_loc_we), .i_loc_wdata(i_loc_wdata),
        .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_addr_err(o_addr_err)
    );

    initial i_mclk = 1'b0;
    always #5 i_mclk = ~i_mclk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    int          err_cnt = 0;
    bit          chk_en = 1'b0;
    longint      t_wv = 0;
    longint      t_rise = 0;
    logic [7:0]  model [16];
    logic [14:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle checker: write events against the queue, local read port against the model.
    always @(negedge i_mclk) begin
        if (chk_en && !i_reset) begin
            if (o_wr_valid) begin
                logic [14:0] e;
                wr_cnt++;
                t_wv = $time;
                chk("wr_valid_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(o_wr_addr), 32'(e[14:8]));
                    chk("wr_data", 32'(o_wr_data), 32'(e[7:0]));
                    model[e[11:8]] = e[7:0];
                end
            end
            if (o_addr_err) err_cnt++;
            chk("loc_rdata", 32'(o_loc_rdata),
                (i_loc_addr < 7'd16) ? 32'(model[i_loc_addr[3:0]]) : 32'd0);
        end
    end

    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit col,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            i_mosi = tx[i];
            #50;
            rx[i] = o_miso;
            i_sclk = 1'b1;
            t_rise = $time;
            if (col && i == 0) begin
                #35;
                i_loc_we = 1'b1;
                model[i_loc_addr[3:0]] = i_loc_wdata;
                #10;
                i_loc_we = 1'b0;
                #5;
            end else begin
                #50;
            end
            i_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] hdr, input logic [7:0] dat, input int nbits,
                             input bit col, output logic [7:0] rx);
        logic [7:0] junk;
        @(posedge i_mclk);
        #1;
        i_cs = 1'b0;
        #100;
        chk("busy_in_frame", 32'(o_busy), 1);
        spi_byte(hdr, 8, 1'b0, junk);
        spi_byte(dat, nbits, col, rx);
        #100;
        i_cs = 1'b1;
        #100;
    endtask

    task automatic loc_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge i_mclk);
        #1;
        i_loc_addr  = a;
        i_loc_wdata = d;
        i_loc_we    = 1'b1;
        model[a[3:0]] = d;
        @(posedge i_mclk);
        #1;
        i_loc_we = 1'b0;
    endtask

    initial begin
        logic [7:0] rx;
        int         wr0;
        i_reset = 1'b1; i_cs = 1'b1; i_sclk = 1'b0; i_mosi = 1'b0;
        i_loc_addr = 7'd0; i_loc_we = 1'b0; i_loc_wdata = 8'h00;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (4) @(posedge i_mclk);
        @(negedge i_mclk);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_miso", 32'(o_miso), 0);
        chk("rst_wr_valid", 32'(o_wr_valid), 0);
        chk("rst_addr_err", 32'(o_addr_err), 0);
        #1;
        i_reset = 1'b0;
        chk_en  = 1'b1;

        // Single write of A5 to address 3
        exp_q.push_back({7'd3, 8'hA5});
        i_loc_addr = 7'd3;
        spi_frame(8'h03, 8'hA5, 8, 1'b0, rx);
        chk("t1_wr_cnt", 32'(wr_cnt), 1);
        chk("t1_latency", 32'(t_wv - t_rise), 44);
        chk("t1_loc_rdata", 32'(o_loc_rdata), 32'h0A5);
        chk("t1_wr_addr", 32'(o_wr_addr), 3);

        // Local write then SPI read of address 5
        loc_write(7'd5, 8'h3C);
        spi_frame(8'h85, 8'h00, 8, 1'b0, rx);
        chk("t2_miso_byte", 32'(rx), 32'h3C);
        chk("t2_wr_cnt", 32'(wr_cnt), 1);
        chk("t2_loc_rdata", 32'(o_loc_rdata), 32'h3C);

        // Out-of-range address 20
        spi_frame(8'h14, 8'hFF, 8, 1'b0, rx);
        chk("t3_addr_err_cnt", 32'(err_cnt), 1);
        chk("t3_wr_cnt", 32'(wr_cnt), 1);
        for (int a = 0; a < 16; a++) begin
            i_loc_addr = 7'(a);
            #10;
            chk("t3_bank_unchanged", 32'(o_loc_rdata), 32'(model[a]));
        end
        i_loc_addr = 7'd20;
        #10;
        chk("t3_oob_loc_rdata", 32'(o_loc_rdata), 0);
        spi_frame(8'h94, 8'h00, 8, 1'b0, rx);
        chk("t3_oob_read", 32'(rx), 0);
        chk("t3_addr_err_cnt2", 32'(err_cnt), 2);

        // Abort after 4 data bits, then a normal frame
        i_loc_addr = 7'd2;
        spi_frame(8'h02, 8'h77, 4, 1'b0, rx);
        chk("t4_busy", 32'(o_busy), 0);
        chk("t4_wr_cnt", 32'(wr_cnt), 1);
        chk("t4_bank2", 32'(o_loc_rdata), 0);
        exp_q.push_back({7'd2, 8'h5A});
        spi_frame(8'h02, 8'h5A, 8, 1'b0, rx);
        chk("t4_wr_cnt2", 32'(wr_cnt), 2);
        chk("t4_bank2_new", 32'(o_loc_rdata), 32'h5A);

        // SPI commit and local write hit address 7 in the same cycle
        i_loc_addr  = 7'd7;
        i_loc_wdata = 8'h22;
        exp_q.push_back({7'd7, 8'h11});
        spi_frame(8'h07, 8'h11, 8, 1'b1, rx);
        chk("t5_spi_wins", 32'(o_loc_rdata), 32'h11);
        chk("t5_wr_data", 32'(o_wr_data), 32'h11);

        // Reset in the middle of a header
        @(posedge i_mclk);
        #1;
        i_cs = 1'b0;
        #100;
        spi_byte(8'h83, 4, 1'b0, rx);
        @(negedge i_mclk);
        #1;
        i_reset = 1'b1;
        i_cs    = 1'b1;
        i_loc_addr = 7'd3;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        exp_q.delete();
        repeat (4) @(posedge i_mclk);
        @(negedge i_mclk);
        chk("t6_busy", 32'(o_busy), 0);
        chk("t6_miso", 32'(o_miso), 0);
        chk("t6_wr_valid", 32'(o_wr_valid), 0);
        chk("t6_wr_addr", 32'(o_wr_addr), 0);
        chk("t6_wr_data", 32'(o_wr_data), 0);
        chk("t6_addr_err", 32'(o_addr_err), 0);
        chk("t6_bank3", 32'(o_loc_rdata), 0);
        #1;
        i_reset = 1'b0;
        wr0 = wr_cnt;
        exp_q.push_back({7'd3, 8'h66});
        spi_frame(8'h03, 8'h66, 8, 1'b0, rx);
        chk("t6_after_reset_wr", 32'(wr_cnt - wr0), 1);
        chk("t6_after_reset_bank3", 32'(o_loc_rdata), 32'h66);

`ifdef SPI_TGT_BURST_EN
        // Burst write wrapping 15 -> 0 -> 1
        wr0 = wr_cnt;
        exp_q.push_back({7'd15, 8'h01});
        exp_q.push_back({7'd0, 8'h02});
        exp_q.push_back({7'd1, 8'h03});
        @(posedge i_mclk);
        #1;
        i_cs = 1'b0;
        #100;
        spi_byte(8'h0F, 8, 1'b0, rx);
        spi_byte(8'h01, 8, 1'b0, rx);
        spi_byte(8'h02, 8, 1'b0, rx);
        spi_byte(8'h03, 8, 1'b0, rx);
        #100;
        i_cs = 1'b1;
        #100;
        chk("t7_burst_wr_cnt", 32'(wr_cnt - wr0), 3);
        i_loc_addr = 7'd15;
        #10;
        chk("t7_bank15", 32'(o_loc_rdata), 32'h01);
        i_loc_addr = 7'd0;
        #10;
        chk("t7_bank0", 32'(o_loc_rdata), 32'h02);
        i_loc_addr = 7'd1;
        #10;
        chk("t7_bank1", 32'(o_loc_rdata), 32'h03);
`endif

        chk("exp_q_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
